// File: rtl/bidir_sipo_receiver_pkg.sv
// Shared definitions for the bidirectional SIPO receiver.
// Covers the bit-order encodings and the frame FSM states.
package bidir_sipo_receiver_pkg;

  localparam logic DIR_LSB_FIRST = 1'b1;
  localparam logic DIR_MSB_FIRST = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

endpackage

// File: rtl/bidir_shift_core.sv
// WIDTH-bit bidirectional shift register with serial input, enable and sync clear.
// Also exposes the post-insertion value so a completing frame can be captured on that edge.
module bidir_shift_core
  import bidir_sipo_receiver_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             dir,
  input  logic             sin,
  output logic [WIDTH-1:0] shifted
);

  logic [WIDTH-1:0] q;

  always_comb begin
    if (dir == DIR_LSB_FIRST) shifted = {sin, q[WIDTH-1:1]};
    else                      shifted = {q[WIDTH-2:0], sin};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= shifted;
  end

endmodule

// File: rtl/bidir_sipo_receiver.sv
// Serial-in/parallel-out receiver: assembles WIDTH-bit frames in either bit order
// and presents them through a valid/ready holding register with sticky overrun.
module bidir_sipo_receiver
  import bidir_sipo_receiver_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             dir,
  input  logic             clear,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dir_lat;
  logic             take;
  logic             frame_dir;
  logic             last_bit;
  logic             complete;
  logic             consume;
  logic [WIDTH-1:0] assembled;

  // A bit taken under clear is discarded, so clear gates every insertion.
  assign take      = sin_valid && !clear;
  assign frame_dir = (state == IDLE) ? dir : dir_lat;
  assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
  assign complete  = take && (state == RECV) && last_bit;
  assign consume   = word_valid && word_ready;
  assign busy      = (state == RECV);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (clear) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (sin_valid) begin
            state_nxt = RECV;
            cnt_nxt   = CNT_W'(1);
          end
        end
        RECV: begin
          if (sin_valid) begin
            if (last_bit) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      dir_lat <= DIR_LSB_FIRST;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (take && (state == IDLE)) dir_lat <= dir;
    end
  end

  // Completion also clears the shifter so the next frame starts from zero.
  bidir_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .en      (take),
    .clr     (clear || complete),
    .dir     (frame_dir),
    .sin     (sin),
    .shifted (assembled)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (complete) begin
        word_out   <= assembled;
        word_valid <= 1'b1;
      end else if (consume) begin
        word_valid <= 1'b0;
      end
      if (clear)                                      overrun <= 1'b0;
      else if (complete && word_valid && !word_ready) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bidir_sipo_receiver.sv
// Directed bench for bidir_sipo_receiver: frame-level reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_bidir_sipo_receiver;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         dir = 1'b1;
  logic         clear = 1'b0;
  logic         word_ready = 1'b0;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         busy;
  logic         overrun;
  logic         chk_en = 1'b0;

  int checks = 0;
  int failures = 0;

  bidir_sipo_receiver #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .dir        (dir),
    .clear      (clear),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Reference model: bits kept in arrival order, word built from the frame's bit order.
  int           m_n;
  logic         m_dir;
  logic [W-1:0] m_arr;
  logic [W-1:0] m_word;
  logic         m_valid;
  logic         m_ov;

  function automatic logic [W-1:0] with_bit(logic [W-1:0] arr, int n, logic b);
    arr[n] = b;
    return arr;
  endfunction

  function automatic logic [W-1:0] assemble(logic [W-1:0] arr, logic lsb_first);
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) begin
      if (lsb_first) w[i] = arr[i];
      else           w[W-1-i] = arr[i];
    end
    return w;
  endfunction

  wire          m_fdir = (m_n == 0) ? dir : m_dir;
  wire [W-1:0]  m_arr_nxt = with_bit(m_arr, m_n, sin);
  wire          m_cons = m_valid && word_ready;
  wire          m_busy = (m_n != 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n <= 0; m_dir <= 1'b1; m_arr <= '0; m_word <= '0; m_valid <= 1'b0; m_ov <= 1'b0;
    end else if (clear) begin
      m_n <= 0; m_arr <= '0; m_ov <= 1'b0;
      if (m_cons) m_valid <= 1'b0;
    end else if (sin_valid && m_n == W - 1) begin
      m_n <= 0; m_arr <= '0;
      m_word <= assemble(m_arr_nxt, m_fdir);
      m_valid <= 1'b1;
      if (m_valid && !word_ready) m_ov <= 1'b1;
    end else begin
      if (sin_valid) begin
        m_n <= m_n + 1; m_arr <= m_arr_nxt; m_dir <= m_fdir;
      end
      if (m_cons) m_valid <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("model word_out", 32'(word_out), 32'(m_word));
      check("model word_valid", 32'(word_valid), 32'(m_valid));
      check("model busy", 32'(busy), 32'(m_busy));
      check("model overrun", 32'(overrun), 32'(m_ov));
    end
  end

  // One cycle of inputs, applied at the falling edge and sampled at the next rising edge.
  task automatic cyc(input logic v, input logic b, input logic d, input logic c, input logic r);
    @(negedge clk);
    sin_valid = v; sin = b; dir = d; clear = c; word_ready = r;
  endtask

  task automatic idle(input logic r);
    cyc(1'b0, 1'b0, dir, 1'b0, r);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset word_out", 32'(word_out), 32'h0);
    check("reset word_valid", 32'(word_valid), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset overrun", 32'(overrun), 32'h0);

    // LSB-first 1,0,1,1 -> 4'hD
    cyc(1, 1, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    check("t1 busy mid", 32'(busy), 32'h1);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    idle(0);
    check("t1 word", 32'(word_out), 32'hD);
    check("t1 valid", 32'(word_valid), 32'h1);
    check("t1 busy", 32'(busy), 32'h0);
    idle(1);
    idle(0);
    check("t1 consumed", 32'(word_valid), 32'h0);

    // MSB-first 1,0,(gap),1,1 with dir toggled after bit 1 -> 4'hB
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    check("t2 not yet valid", 32'(word_valid), 32'h0);
    idle(0);
    check("t2 word", 32'(word_out), 32'hB);
    check("t2 valid", 32'(word_valid), 32'h1);
    idle(1);

    // Back-to-back 4'hA then 4'h5, LSB-first, never consumed -> overrun
    cyc(1, 0, 1, 0, 0); cyc(1, 1, 1, 0, 0); cyc(1, 0, 1, 0, 0); cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    check("t3 first word", 32'(word_out), 32'hA);
    cyc(1, 0, 1, 0, 0); cyc(1, 1, 1, 0, 0); cyc(1, 0, 1, 0, 0);
    idle(0);
    check("t3 word", 32'(word_out), 32'h5);
    check("t3 valid", 32'(word_valid), 32'h1);
    check("t3 overrun", 32'(overrun), 32'h1);
    cyc(0, 0, 1, 1, 0);
    idle(0);
    check("t3 clr overrun", 32'(overrun), 32'h0);
    check("t3 clr word", 32'(word_out), 32'h5);
    check("t3 clr valid", 32'(word_valid), 32'h1);

    // Completion with ready on the pending word: 1,1,0,0 LSB-first -> 4'h3, no overrun
    cyc(1, 1, 1, 0, 0); cyc(1, 1, 1, 0, 0); cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 1);
    idle(0);
    check("t4 word", 32'(word_out), 32'h3);
    check("t4 valid", 32'(word_valid), 32'h1);
    check("t4 overrun", 32'(overrun), 32'h0);
    idle(1);

    // Abort after two bits with clear+sin_valid, then 0,1,1,0 LSB-first -> 4'h6
    cyc(1, 1, 1, 0, 0); cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 1, 0);
    idle(0);
    check("t5 busy", 32'(busy), 32'h0);
    check("t5 no word", 32'(word_valid), 32'h0);
    cyc(1, 0, 1, 0, 0); cyc(1, 1, 1, 0, 0); cyc(1, 1, 1, 0, 0); cyc(1, 0, 1, 0, 0);
    idle(0);
    check("t5 word", 32'(word_out), 32'h6);
    check("t5 valid", 32'(word_valid), 32'h1);
    idle(1);

    // Asynchronous reset mid-frame, then MSB-first 1,0,0,1 -> 4'h9
    cyc(1, 1, 1, 0, 0); cyc(1, 0, 1, 0, 0);
    idle(0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6 rst word_out", 32'(word_out), 32'h0);
    check("t6 rst valid", 32'(word_valid), 32'h0);
    check("t6 rst busy", 32'(busy), 32'h0);
    check("t6 rst overrun", 32'(overrun), 32'h0);
    #1 rst = 1'b0;
    cyc(1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0);
    idle(0);
    check("t6 word", 32'(word_out), 32'h9);
    check("t6 valid", 32'(word_valid), 32'h1);
    idle(1);

    // Clear on the completing edge discards the word
    cyc(1, 1, 1, 0, 0); cyc(1, 1, 1, 0, 0); cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 1, 0);
    idle(0);
    check("t7 discarded", 32'(word_valid), 32'h0);
    check("t7 word kept", 32'(word_out), 32'h9);
    check("t7 busy", 32'(busy), 32'h0);
    idle(0);
    idle(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bidir_sipo_receiver.md
Name: bidir_sipo_receiver

Overview:
Serial-in/parallel-out receiver for the serial streams our bidirectional shift registers emit. It samples one bit per qualified clock, assembles WIDTH-bit words in either bit order, and presents each completed word through a valid/ready output holding register. It sits at the receiving end of the serial link, feeding parallel consumers.

Parameters:
WIDTH, 4, word length in bits (>=2); also the frame length in bits.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
sin  input  1  serial data bit.
sin_valid  input  1  sin is sampled on this clock edge when high.
dir  input  1  bit order: 1 = LSB-first (shift right), 0 = MSB-first (shift left); latched per frame.
clear  input  1  synchronous frame abort; discards any partial word.
word_out  output  WIDTH  last completed word.
word_valid  output  1  word_out holds an unconsumed word.
word_ready  input  1  consumer accepts word_out when word_valid && word_ready.
busy  output  1  a frame is in progress (state RECV).
overrun  output  1  sticky: a completed word overwrote an unconsumed one.

Behaviour:
- Reset (async, rst=1): state IDLE, shift register 0, bit counter 0, latched dir 1, word_out 0, word_valid 0, busy 0, overrun 0. Reset mid-frame discards the partial word with no output.
- FSM states: IDLE (no bits held), RECV (1..WIDTH-1 bits held).
- IDLE: on sin_valid, latch dir, insert first bit, counter=1, go to RECV. Exception for WIDTH-bit completion does not apply here because WIDTH>=2.
- RECV: each sin_valid inserts one bit and increments the counter; sin_valid low holds all state (gaps allowed, no timeout).
- Insertion: latched dir=1 -> shift right, new bit enters MSB, so the first bit received ends in bit 0. Latched dir=0 -> shift left, new bit enters bit 0, so the first bit received ends in MSB. Bits are stored uninverted in both orders.
- dir is sampled only on the first bit of a frame; changes mid-frame are ignored until the next frame.
- Completion: on the edge that accepts bit WIDTH, load the assembled word into word_out and set word_valid. Return to IDLE with counter 0.
  - word_valid is therefore visible one cycle after the cycle in which the last bit is presented (1-cycle latency).
  - Back-to-back frames need no idle cycle.
- Handshake: word_valid && word_ready at an edge clears word_valid; word_out holds its value. word_valid stays high until it is consumed.
- Completion while word_valid=1 and word_ready=0: the new word overwrites word_out, word_valid stays 1, overrun is set.
- Completion while word_valid=1 and word_ready=1 in the same cycle: the old word is consumed, the new word is loaded, word_valid stays 1, and overrun is not set.
- clear: state goes to IDLE, counter 0, shift register 0; word_out, word_valid and overrun are unaffected except that clear also resets overrun to 0. Clear has priority over a simultaneous sin_valid, and that bit is discarded. Clear on the completing edge discards the word.
- busy = (state == RECV).
- Counter width: clog2(WIDTH)+1 bits; no wrap beyond WIDTH.

Decomposition:
- Shared package: DIR_LSB_FIRST = 1'b1 and DIR_MSB_FIRST = 1'b0; state typedef {IDLE, RECV}.
- One natural sub-module: bidir_shift_core, a WIDTH-bit register with serial input, a direction select, an enable, and a synchronous clear. The FSM, counter and output holding register stay in the top module.

Test Plan:
1. WIDTH=4, dir=1, sin_valid bits 1,0,1,1 on consecutive cycles -> next cycle word_out=4'hD, word_valid=1, busy=0.
2. dir=0, bits 1,0,1,1 with sin_valid low for 2 cycles between bits 2 and 3 -> word_out=4'hB, arriving 1 cycle after the 4th bit. Toggling dir after bit 1 has no effect on the result.
3. Two back-to-back frames 4'hA then 4'h5 with word_ready=0 -> word_out=4'h5, word_valid=1, overrun=1. Then pulse clear -> overrun=0 and word_out stays 4'h5.
4. Completion coinciding with word_ready=1 on a pending word -> new word loaded, word_valid stays 1, overrun stays 0.
5. Two bits sent, then clear asserted with sin_valid=1 -> busy=0. The next 4 bits 0,1,1,0 with dir=1 give word_out=4'h6 and show no residue from the aborted frame.
6. Assert rst asynchronously between clock edges mid-frame -> all outputs 0 immediately. A following full frame decodes correctly.
